// File: rtl/alu_rr_sequencer.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// Optional sticky overflow flag: define ALU_RR_STICKY_OVF_EN.
module alu_rr_sequencer #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic        rsp_zero,
`ifdef ALU_RR_STICKY_OVF_EN
    input  logic        ovf_clr,
    output logic        ovf_sticky,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        prio;
    logic        cur_id;
    logic        grant0;
    logic        grant1;
    logic        take;
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;

    // prio==0 favours req0 on a tie, prio==1 favours req1
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ~prio);
        grant1 = req1_valid & (~req0_valid | prio);
        take   = (state == IDLE) & (grant0 | grant1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (grant0 | grant1) state_nx = EXEC;
            EXEC: state_nx = RESP;
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == IDLE) & grant0 & ~rst;
        req1_ready = (state == IDLE) & grant1 & ~rst;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio   <= PRIO_INIT;
            cur_id <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (take) begin
            prio   <= grant0;
            cur_id <= grant1;
            op_q   <= grant1 ? req1_op : req0_op;
            a_q    <= grant1 ? req1_a : req0_a;
            b_q    <= grant1 ? req1_b : req0_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else if (state == EXEC) begin
            rsp_id       <= cur_id;
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
        end
    end

`ifdef ALU_RR_STICKY_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end else if ((state == EXEC) && alu_overflow) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench for alu_rr_sequencer with a behavioural ALU attached.
// Define ALU_RR_STICKY_OVF_EN to exercise the sticky overflow flag.
module tb_alu_rr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op;
    logic [15:0] req1_a, req1_b;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_carry, alu_overflow, alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_carry, rsp_overflow, rsp_zero;
    logic        busy;
`ifdef ALU_RR_STICKY_OVF_EN
    logic        ovf_clr;
    logic        ovf_sticky;
`endif

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    exp_t sbq[$];
    int   acc_q[$];
    int   gcyc[$];
    logic gid[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic rv_d = 1'b0;

    alu_rr_sequencer #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
        .rsp_zero(rsp_zero),
`ifdef ALU_RR_STICKY_OVF_EN
        .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {carry, overflow, zero, result}
    function automatic logic [18:0] alu_ref(
        input logic [3:0] op,
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        logic c, v;
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                c = s[16];
                v = (a[15] == b[15]) && (s[15] != a[15]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b};
                c = s[16];
                v = (a[15] != b[15]) && (s[15] != a[15]);
            end
            4'd2: s[15:0] = a & b;
            4'd3: s[15:0] = a | b;
            4'd4: s[15:0] = a ^ b;
            4'd5: s[15:0] = ~a;
            4'd6: s[15:0] = a << 1;
            4'd7: s[15:0] = a >> 1;
            4'd8: s[15:0] = a + 16'd1;
            4'd9: s[15:0] = a - 16'd1;
            default: s = '0;
        endcase
        return {c, v, (s[15:0] == 16'd0), s[15:0]};
    endfunction

    always_comb begin
        {alu_carry, alu_overflow, alu_zero, alu_result} =
            alu_ref(alu_op, alu_a, alu_b);
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [18:0] r;
        if (!rst) begin
            if (req0_ready || req1_ready) begin
                chk("one_grant", {31'd0, req0_ready & req1_ready}, 0);
                if (req1_ready) r = alu_ref(req1_op, req1_a, req1_b);
                else r = alu_ref(req0_op, req0_a, req0_b);
                e.id  = req1_ready;
                e.res = r[15:0];
                e.z   = r[16];
                e.v   = r[17];
                e.c   = r[18];
                sbq.push_back(e);
                acc_q.push_back(cyc);
                gcyc.push_back(cyc);
                gid.push_back(req1_ready);
            end
            if (rsp_valid && !rv_d) begin
                chk("lat_pending", {31'd0, acc_q.size() != 0}, 1);
                if (acc_q.size() != 0)
                    chk("latency", cyc - acc_q[0], 2);
            end
            if (rsp_valid && rsp_ready) begin
                chk("sb_pending", {31'd0, sbq.size() != 0}, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    void'(acc_q.pop_front());
                    chk("sb_id", {31'd0, rsp_id}, {31'd0, e.id});
                    chk("sb_res", {16'd0, rsp_result}, {16'd0, e.res});
                    chk("sb_flags",
                        {29'd0, rsp_carry, rsp_overflow, rsp_zero},
                        {29'd0, e.c, e.v, e.z});
                end
            end
        end
        rv_d = rsp_valid;
    end

    initial begin
        int base;
        rst = 1'b1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 1'b1;
`ifdef ALU_RR_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
        chk("rst_busy", {30'd0, busy, rsp_valid}, 0);
        chk("rst_rsp", {12'd0, rsp_result, rsp_id,
            rsp_carry, rsp_overflow, rsp_zero}, 0);
        chk("rst_alu", {alu_op, alu_a, alu_b[11:0]}, 0);
`ifdef ALU_RR_STICKY_OVF_EN
        chk("rst_sticky", {31'd0, ovf_sticky}, 0);
`endif
        rst = 1'b0;

        // ADD 10+5 from req0
        tick();
        req0_valid = 1; req0_op = 4'd0; req0_a = 16'd10; req0_b = 16'd5;
        samp();
        chk("t1_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
        tick();
        req0_valid = 0;
        samp();
        chk("t1_exec", {30'd0, busy, rsp_valid}, 32'd2);
        chk("t1_alu_a", {16'd0, alu_a}, 32'd10);
        samp();
        chk("t1_rv", {31'd0, rsp_valid}, 1);
        chk("t1_res", {16'd0, rsp_result}, 32'd15);
        chk("t1_id", {31'd0, rsp_id}, 0);
        chk("t1_flg", {29'd0, rsp_carry, rsp_overflow, rsp_zero}, 0);
        samp();
        chk("t1_idle", {31'd0, busy}, 0);

        // ADD 32767+1 from req1 wraps negative
        tick();
        req1_valid = 1; req1_op = 4'd0;
        req1_a = 16'h7fff; req1_b = 16'd1;
        samp();
        chk("t2_ready", {30'd0, req0_ready, req1_ready}, 1);
        tick();
        req1_valid = 0;
        samp();
        samp();
        chk("t2_res", {16'd0, rsp_result}, 32'h8000);
        chk("t2_ovf", {31'd0, rsp_overflow}, 1);
        chk("t2_id", {31'd0, rsp_id}, 1);
`ifdef ALU_RR_STICKY_OVF_EN
        samp();
        samp();
        chk("t2_sticky", {31'd0, ovf_sticky}, 1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        samp();
        chk("t2_clr", {31'd0, ovf_sticky}, 0);
`endif

        // both requesters continuously valid
        tick();
        base = gcyc.size();
        req0_valid = 1; req0_op = 4'd0; req0_a = 16'd100; req0_b = 16'd1;
        req1_valid = 1; req1_op = 4'd1; req1_a = 16'd200; req1_b = 16'd2;
        for (int i = 0; i < 40; i++) begin
            samp();
            if (gcyc.size() >= base + 4) break;
        end
        chk("t3_count", {31'd0, gcyc.size() >= base + 4}, 1);
        tick();
        req0_valid = 0;
        req1_valid = 0;
        if (gcyc.size() >= base + 4) begin
            chk("t3_order", {28'd0, gid[base], gid[base+1],
                gid[base+2], gid[base+3]}, 32'b0101);
            for (int i = 1; i < 4; i++)
                chk("t3_gap", {31'd0,
                    (gcyc[base+i] - gcyc[base+i-1]) >= 3}, 1);
        end
        for (int i = 0; i < 30 && sbq.size() != 0; i++) samp();
        chk("t3_drain", sbq.size(), 0);

        // SUB 10-5 with back-pressure, req1 waiting meanwhile
        tick();
        rsp_ready = 0;
        req0_valid = 1; req0_op = 4'd1; req0_a = 16'd10; req0_b = 16'd5;
        samp();
        chk("t4_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'd0; req1_a = 16'd3; req1_b = 16'd4;
        samp();
        chk("t4_exec_hold", {31'd0, req1_ready}, 0);
        for (int k = 0; k < 5; k++) begin
            samp();
            chk("t4_rv", {31'd0, rsp_valid}, 1);
            chk("t4_res", {16'd0, rsp_result}, 32'd5);
            chk("t4_id", {31'd0, rsp_id}, 0);
            chk("t4_hold", {30'd0, req0_ready, req1_ready}, 0);
        end
        tick();
        rsp_ready = 1;
        samp();
        chk("t4_hs", {31'd0, rsp_valid}, 1);
        samp();
        chk("t4_idle", {31'd0, busy}, 0);
        chk("t4_late", {30'd0, req0_ready, req1_ready}, 1);
        tick();
        req1_valid = 0;
        for (int i = 0; i < 30 && sbq.size() != 0; i++) samp();
        chk("t4_drain", sbq.size(), 0);

        // reset during EXEC discards the command
        tick();
        req0_valid = 1; req0_op = 4'd0; req0_a = 16'd1; req0_b = 16'd2;
        samp();
        chk("t5_ready", {31'd0, req0_ready}, 1);
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'd0; req1_a = 16'd5; req1_b = 16'd6;
        chk("t5_inexec", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", {30'd0, busy, rsp_valid}, 0);
        chk("t5_ready0", {30'd0, req0_ready, req1_ready}, 0);
        chk("t5_rsp", {15'd0, rsp_result, rsp_id}, 0);
        chk("t5_alu", {12'd0, alu_op, alu_a}, 0);
        if (sbq.size() != 0) begin
            void'(sbq.pop_back());
            void'(acc_q.pop_back());
        end
        tick();
        rst = 1'b0;
        samp();
        chk("t5_regrant", {30'd0, req0_ready, req1_ready}, 1);
        tick();
        req1_valid = 0;
        chk("t5_taken", {31'd0, busy}, 1);
        for (int i = 0; i < 30 && sbq.size() != 0; i++) samp();
        chk("t5_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rr_sequencer.md
ALU_RR_SEQUENCER -- requirements
Module: alu_rr_sequencer

Interface
REQ-001 SHALL have parameter PRIO_INIT, default 0: requester that holds priority after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester command valid.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  command accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  4 each  ALU opcode (0000 ADD … 1001 DEC).
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16 each  signed operands.
REQ-008 SHALL have ports alu_a, alu_b  output  16  and alu_op  output  4; these drive the shared combinational 16-bit ALU.
REQ-009 SHALL have ports alu_result  input  16  and alu_carry, alu_overflow, alu_zero  input  1 each; these are returned from the ALU.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (granted requester), rsp_result  output  16, rsp_carry / rsp_overflow / rsp_zero  output  1 each.
REQ-011 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE, when any reqN_valid is high, the block SHALL grant exactly one requester, pulse its reqN_ready for one cycle, latch op/a/b into operand registers, and move to EXEC.
REQ-014 Arbitration SHALL be round-robin: if both requesters are valid, the priority holder wins; after each grant, priority SHALL pass to the other requester.
REQ-015 If only one requester is valid, it SHALL be granted regardless of priority, and priority SHALL still toggle away from it.
REQ-016 reqN_ready SHALL be high only in IDLE for the granted requester; it SHALL never be high for both requesters, and SHALL be low in EXEC and RESP.
REQ-017 alu_a, alu_b and alu_op SHALL come only from the operand registers, never directly from requester inputs.
REQ-018 In EXEC, which lasts exactly one cycle, alu_result and the three flags SHALL be captured into response registers, rsp_id SHALL be set, and the FSM SHALL move to RESP.
REQ-019 In RESP, rsp_valid SHALL be high; all rsp_* outputs SHALL hold stable until rsp_ready is sampled high, and the FSM SHALL then return to IDLE.
REQ-020 Command-acceptance to rsp_valid latency SHALL be 2 cycles, and the minimum issue interval SHALL be 3 cycles.
REQ-021 Requests arriving during EXEC or RESP SHALL be held off (ready low) and SHALL NOT be lost while valid is held.
REQ-022 rsp_result SHALL pass through the ALU's signed 16-bit wrap-around result unmodified; the block SHALL NOT saturate or sign-extend it.

Reset
REQ-023 Asserting rst SHALL immediately force: state IDLE; all ready outputs 0; rsp_valid 0; busy 0; rsp_result, rsp_id and all flags 0; operand registers and alu_a/alu_b/alu_op 0; priority = PRIO_INIT.
REQ-024 Reset asserted in EXEC or RESP SHALL discard the in-flight command with no response; after release, the first valid request SHALL be granted on the next edge.

Configuration
REQ-025 When ALU_RR_STICKY_OVF_EN is defined, the block SHALL add output ovf_sticky (1 bit) and input ovf_clr (1 bit).
REQ-026 With the macro defined, ovf_sticky SHALL set in the cycle a captured alu_overflow is 1, SHALL clear on ovf_clr (clear wins when both occur together), and SHALL reset to 0.
REQ-027 When ALU_RR_STICKY_OVF_EN is undefined, those ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Bench SHALL cover: req0 ADD a=10 b=5, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_result=15, rsp_id=0, carry=overflow=zero=0.
REQ-029 Bench SHALL cover: req1 ADD a=32767 b=1 -> rsp_result=-32768, rsp_overflow=1; with macro defined, ovf_sticky=1 until ovf_clr.
REQ-030 Bench SHALL cover: both requesters continuously valid with PRIO_INIT=0 -> grant order 0,1,0,1, with grants at least 3 cycles apart.
REQ-031 Bench SHALL cover: rsp_ready held low 5 cycles after SUB a=10 b=5 -> rsp_valid and rsp_result=5 stable all 5 cycles, no new grant, then IDLE.
REQ-032 Bench SHALL cover: rst pulsed during EXEC -> outputs zero immediately, no response issued, and a pending request is granted on the first edge after release.
